// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq_hz,
                                                 input int unsigned baud);
        return clk_freq_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, detects start edge, samples each bit mid-period.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);
    import uart_pkg::*;

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic [1:0]       sync_q;
    logic             prev_q;
    logic             rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Re-check the line half a bit in; a high level means it was a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    data_d  = shreg_q;
                    valid_d = rx_s;
                    ferr_d  = !rx_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;

endmodule

// File: rtl/uart_if.sv
// Full-duplex 8N1 UART: inline transmitter plus uart_rx receiver.
module uart_if #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD        = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);
    import uart_pkg::*;

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    // tx is registered from the next state so the line never glitches.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    state_d = START;
                    shreg_d = tx_data;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_ready = (state_q == IDLE);
    assign tx       = tx_q;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err)
    );

endmodule

// File: tb/tb_uart_if.sv
// Directed plus randomized bench for uart_if at 104 clocks per bit.
module tb_uart_if;
    localparam int unsigned CPB = 104;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       rx_line;
    logic       rx_drive = 1'b1;
    logic       loop_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int unsigned ferr_cnt = 0;

    always #5 clk = ~clk;

    assign rx_line = loop_en ? tx : rx_drive;

    uart_if #(
        .CLK_FREQ_HZ(1_000_000),
        .BAUD       (9600)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx          (tx),
        .rx          (rx_line),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err)
    );

    // Receive-side observer: collects every pulse seen on the outputs.
    always @(negedge clk) begin
        if (rx_valid) got_q.push_back(rx_data);
        if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Handshake one byte; afterwards tx_data is scrambled to prove it was captured.
    task automatic start_tx(input logic [7:0] b);
        int i;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        i = 0;
        while (!tx_ready && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check("tx_ready_wait", 32'(tx_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic send_check(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        start_tx(b);
        repeat (CPB / 2 - 1) @(negedge clk);
        check("tx_busy", 32'(tx_ready), 32'd0);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) repeat (CPB) @(negedge clk);
            check($sformatf("tx_bit%0d_of_%02h", k, b), 32'(tx), 32'(f[k]));
        end
        repeat (CPB / 2) @(negedge clk);
        check("tx_ready_early", 32'(tx_ready), 32'd0);
        @(negedge clk);
        check("tx_ready_after_1040", 32'(tx_ready), 32'd1);
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drive = f[k];
            repeat (CPB) @(negedge clk);
        end
        rx_drive = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic check_received(input string tag);
        logic [7:0] g;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            check({tag, "_byte"}, 32'(g), 32'(exp_q.pop_front()));
        end
        got_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        int i;

        do_reset();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_ferr", 32'(rx_frame_err), 32'd0);

        send_check(8'h23);
        repeat (2) send_check(8'($urandom));

        exp_q.push_back(8'h51);
        drive_rx(8'h51, 1'b1);
        check("rx51_data", 32'(rx_data), 32'h51);
        check("rx51_ferr", ferr_cnt, 32'd0);
        check_received("rx51");

        for (int r = 0; r < 3; r++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            drive_rx(b, 1'b1);
        end
        check_received("rx_rand");

        drive_rx(8'hA5, 1'b0);
        check("ferr_count", ferr_cnt, 32'd1);
        check("ferr_data", 32'(rx_data), 32'hA5);
        check_received("ferr_no_valid");

        @(negedge clk);
        rx_drive = 1'b0;
        repeat (20) @(negedge clk);
        rx_drive = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_ferr", ferr_cnt, 32'd1);
        check("glitch_hold_data", 32'(rx_data), 32'hA5);
        check_received("glitch_no_valid");
        b = 8'($urandom);
        exp_q.push_back(b);
        drive_rx(b, 1'b1);
        check_received("after_glitch");

        loop_en = 1'b1;
        exp_q.push_back(8'h23);
        exp_q.push_back(8'h51);
        start_tx(8'h23);
        start_tx(8'h51);
        i = 0;
        while (got_q.size() < 2 && i < 3000) begin
            @(negedge clk);
            i++;
        end
        repeat (200) @(negedge clk);
        check_received("loopback");

        for (int r = 0; r < 2; r++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            start_tx(b);
        end
        i = 0;
        while (got_q.size() < 2 && i < 3000) begin
            @(negedge clk);
            i++;
        end
        repeat (200) @(negedge clk);
        check_received("loop_rand");
        loop_en = 1'b0;

        drive_rx_partial: begin
            rx_drive = 1'b0;
            repeat (4 * CPB) @(negedge clk);
            rx_drive = 1'b1;
        end
        do_reset();
        repeat (1500) @(negedge clk);
        check("rx_abort_ferr", ferr_cnt, 32'd1);
        check("rx_abort_data", 32'(rx_data), 32'd0);
        check_received("rx_abort_no_valid");

        start_tx(8'hFF);
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("tx_abort_tx", 32'(tx), 32'd1);
        check("tx_abort_ready", 32'(tx_ready), 32'd1);
        rst = 1'b0;
        send_check(8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
